// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I constants and the fetch entry bundle.
// Used by the fetch unit, its prefetch queue and decode.
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 10;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;
  localparam logic [6:0] OPC_L = 7'b0000011;
  localparam logic [6:0] OPC_S = 7'b0100011;
  localparam logic [6:0] OPC_J = 7'b1101111;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [XLEN-1:0]   ir;
  } fetch_entry_t;

endpackage

// File: rtl/rv_fetch_unit_if.sv
// rv_imem_if: fetch <-> imem read port (1-cycle latency).
// rv_dec_if: fetch -> decode valid/ready handshake.
interface rv_imem_if #(
  parameter int ADDR_W = 10,
  parameter int XLEN   = 32
);
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [XLEN-1:0]   imem_rdata;

  modport master (
    output imem_en, imem_addr,
    input  imem_rdata
  );
  modport slave (
    input  imem_en, imem_addr,
    output imem_rdata
  );
endinterface

interface rv_dec_if #(
  parameter int ADDR_W = 10,
  parameter int XLEN   = 32
);
  logic              if_valid;
  logic              if_ready;
  logic [XLEN-1:0]   if_ir;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_npc;

  modport master (
    output if_valid, if_ir, if_pc, if_npc,
    input  if_ready
  );
  modport slave (
    input  if_valid, if_ir, if_pc, if_npc,
    output if_ready
  );
endinterface

// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue: DEPTH-entry synchronous FIFO of fetch entries.
// Flush empties it in one cycle; pointers wrap mod DEPTH.
module rv_fetch_queue
  import rv_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk1,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  entry_t                 i_wdata,
  output entry_t                 o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty
);
  localparam int PW = $clog2(DEPTH);

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_rd;
  logic [PW-1:0]   r_wr;
  logic [PW:0]     r_cnt;

  // Pointer/count update; storage written on push.
  always_ff @(posedge clk1) begin
    if (i_rst || i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_wdata;
        r_wr        <= r_wr + 1'b1;
      end
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + {{PW{1'b0}}, i_push}
                     - {{PW{1'b0}}, i_pop};
    end
  end

  assign o_rdata = r_mem[r_rd];
  assign o_count = r_cnt;
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: RV32I fetch stage with prefetch queue and redirect.
// Optional RV_FETCH_PERF_EN adds saturating fetch/squash counters.
module rv_fetch_unit
  import rv_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter int                ADDR_W   = 10,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              halted,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  rv_imem_if.master         imem,
  rv_dec_if.master          dec
`ifdef RV_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_squashed
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [XLEN-1:0]   ir;
  } entry_t;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;

  logic [CW-1:0]     w_cnt;
  logic [CW:0]       w_used;
  logic              w_empty;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  entry_t            w_head;
  entry_t            w_wdata;

  assign w_used  = {1'b0, w_cnt} + {{CW{1'b0}}, r_inflight};
  assign w_issue = !rst && !halted && !redirect_valid
                && (w_used < (CW+1)'(DEPTH));
  assign w_push  = r_inflight && !redirect_valid && !rst;
  assign w_valid = !w_empty && !redirect_valid && !rst;
  assign w_pop   = w_valid && dec.if_ready;
  assign w_wdata = '{pc: r_inflight_pc, ir: imem.imem_rdata};

  assign imem.imem_en   = w_issue;
  assign imem.imem_addr = r_pc;

  assign dec.if_valid = w_valid;
  assign dec.if_ir    = w_head.ir;
  assign dec.if_pc    = w_head.pc;
  assign dec.if_npc   = w_head.pc + 1'b1;

  // PC and in-flight tracking; redirect drops the pending return.
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc          <= r_pc + 1'b1;
        r_inflight_pc <= r_pc;
      end
    end
  end

  rv_fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk1    (clk1),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_count (w_cnt),
    .o_empty (w_empty)
  );

`ifdef RV_FETCH_PERF_EN
  logic [32:0] w_fetch_sum;
  logic [32:0] w_squash_sum;
  logic [CW:0] w_squash_inc;

  assign w_squash_inc = (redirect_valid && !rst) ? w_used : '0;
  assign w_fetch_sum  = {1'b0, perf_fetched} + 33'(w_push);
  assign w_squash_sum = {1'b0, perf_squashed} + 33'(w_squash_inc);

  // Saturating event counters.
  always_ff @(posedge clk1) begin
    if (rst) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      perf_fetched  <= w_fetch_sum[32]  ? '1 : w_fetch_sum[31:0];
      perf_squashed <= w_squash_sum[32] ? '1 : w_squash_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_rv_fetch_unit.sv
// tb_rv_fetch_unit: directed stimulus with a PC scoreboard
// checked by an independent decode-side monitor.
module tb_rv_fetch_unit;
  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          halted;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
`ifdef RV_FETCH_PERF_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_squashed;
`endif

  always #5 clk1 = ~clk1;

  rv_imem_if #(.ADDR_W(AW), .XLEN(32)) imem ();
  rv_dec_if  #(.ADDR_W(AW), .XLEN(32)) dec ();

  rv_fetch_unit #(
    .XLEN     (32),
    .ADDR_W   (AW),
    .DEPTH    (DEPTH),
    .RESET_PC ('0)
  ) dut (
    .clk1           (clk1),
    .rst            (rst),
    .halted         (halted),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .dec            (dec)
`ifdef RV_FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_squashed  (perf_squashed)
`endif
  );

  function automatic logic [31:0] memf(input logic [AW-1:0] a);
    return 32'h100 + 32'(a);
  endfunction

  // 1-cycle-latency instruction memory model
  always @(posedge clk1)
    if (imem.imem_en) imem.imem_rdata <= memf(imem.imem_addr);

  int            n_cmp = 0;
  int            n_err = 0;
  logic [AW-1:0] exp_q [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  // scoreboard monitor: every transfer to decode pops one expected PC
  always @(negedge clk1) begin
    if (dec.if_valid && dec.if_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got pc %0h expected none",
                 dec.if_pc);
      end else begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        chk("sb_pc",  32'(dec.if_pc),  32'(e));
        chk("sb_ir",  dec.if_ir,       memf(e));
        chk("sb_npc", 32'(dec.if_npc), 32'(AW'(e + 1'b1)));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int            n_iss;
    int            w;
    logic          seen0;

    rst            = 1'b1;
    halted         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec.if_ready   = 1'b1;
    tick;
    tick;
    chk("rst_en",    32'(imem.imem_en), 0);
    chk("rst_valid", 32'(dec.if_valid), 0);
`ifdef RV_FETCH_PERF_EN
    chk("rst_perf_f", perf_fetched,  0);
    chk("rst_perf_s", perf_squashed, 0);
`endif

    // 1: sequential stream, one per cycle, first valid at cycle 2
    for (int i = 0; i < 64; i++) exp_q.push_back(AW'(i));
    rst = 1'b0;
    #1;
    chk("t1_c0_en",   32'(imem.imem_en),   1);
    chk("t1_c0_addr", 32'(imem.imem_addr), 0);
    tick;
    chk("t1_c1_valid", 32'(dec.if_valid), 0);
    tick;
    chk("t1_c2_valid", 32'(dec.if_valid), 1);
    chk("t1_c2_pc",    32'(dec.if_pc),    0);
    repeat (10) tick;

    // 2: decode stalls; queue fills to DEPTH, head held
    rst          = 1'b1;
    dec.if_ready = 1'b0;
    tick;
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(AW'(i));
    rst   = 1'b0;
    n_iss = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (imem.imem_en) n_iss++;
      if (dec.if_valid) chk("t2_head_pc", 32'(dec.if_pc), 0);
      tick;
    end
    #1;
    chk("t2_issues",   n_iss, DEPTH);
    chk("t2_stall_en", 32'(imem.imem_en),  0);
    chk("t2_full_vld", 32'(dec.if_valid),  1);
    dec.if_ready = 1'b1;
    repeat (8) tick;

    // 3: redirect with a backed-up queue and a read in flight
    dec.if_ready = 1'b0;
    tick;
    tick;
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(AW'(10'h40 + i));
    redirect_valid = 1'b1;
    redirect_pc    = 10'h40;
    dec.if_ready   = 1'b1;
    #1;
    chk("t3_vld_forced0", 32'(dec.if_valid), 0);
    chk("t3_no_issue",    32'(imem.imem_en), 0);
    tick;
    redirect_valid = 1'b0;
    #1;
    chk("t3_fetch_en",   32'(imem.imem_en),   1);
    chk("t3_fetch_addr", 32'(imem.imem_addr), 32'h40);
    w = 0;
    while (!dec.if_valid && w < 5) begin
      tick;
      w++;
    end
    chk("t3_wait_valid", 32'(dec.if_valid), 1);
    chk("t3_first_pc",   32'(dec.if_pc),    32'h40);
    repeat (6) tick;

    // 4: halt drains the queue, then resumes at held pc
    halted = 1'b1;
    #1;
    chk("t4_en_off", 32'(imem.imem_en), 0);
    repeat (4) begin
      tick;
      chk("t4_en_held", 32'(imem.imem_en), 0);
    end
    chk("t4_drained", 32'(dec.if_valid), 0);
    halted = 1'b0;
    #1;
    chk("t4_resume_en",   32'(imem.imem_en),   1);
    chk("t4_resume_addr", 32'(imem.imem_addr), 32'(exp_q[0]));
    repeat (6) tick;

    // 5: pc wraps from 2^ADDR_W-1 to 0
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(AW'(10'h3FE + i));
    redirect_valid = 1'b1;
    redirect_pc    = 10'h3FE;
    tick;
    redirect_valid = 1'b0;
    seen0          = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (imem.imem_en && imem.imem_addr == '0) seen0 = 1'b1;
      tick;
    end
    chk("t5_wrap_addr", 32'(seen0), 1);

    // 6: reset with a non-empty queue
    dec.if_ready = 1'b0;
    tick;
    tick;
    chk("t6_nonempty", 32'(dec.if_valid), 1);
`ifdef RV_FETCH_PERF_EN
    chk("t6_perf_f_nz", 32'(perf_fetched != 0), 1);
`endif
    rst = 1'b1;
    tick;
    chk("t6_valid", 32'(dec.if_valid),   0);
    chk("t6_addr",  32'(imem.imem_addr), 0);
    chk("t6_en",    32'(imem.imem_en),   0);
`ifdef RV_FETCH_PERF_EN
    chk("t6_perf_f", perf_fetched,  0);
    chk("t6_perf_s", perf_squashed, 0);
`endif
    rst = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
